// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared reset address, fetch FSM states and FIFO entry type
package inst_fetch_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  typedef enum logic [1:0] {IDLE, RUN, WAIT, DROP} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_fifo.sv
// fetch_fifo: prefetch FIFO of {pc, inst} entries with push, pop and flush-all-but-head
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  fetch_entry_t  data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic          keep_i,
  output fetch_entry_t  head_o,
  output logic [31:0]   next_pc_o,
  output logic [CW-1:0] count_o
);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d, wr_m, rd_n;
  logic [CW-1:0] cnt_q, cnt_d, cnt_m;
  always_comb begin
    rd_d = rd_q + AW'(pop_i);
    wr_m = flush_i ? rd_d + AW'(keep_i) : wr_q;
    wr_d = wr_m + AW'(push_i);
    cnt_m = flush_i ? CW'(keep_i) : cnt_q - CW'(pop_i);
    cnt_d = cnt_m + CW'(push_i);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (push_i) mem_q[wr_m] <= data_i;
  assign rd_n = rd_q + AW'(1);
  assign head_o = mem_q[rd_q];
  assign next_pc_o = mem_q[rd_n].pc;
  assign count_o = cnt_q;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: fetch PC, single-outstanding imem handshake, prefetch FIFO and delay-slot-preserving redirect
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        isbranch,
  input  logic [31:0] branch_pc,
  input  logic        id_stall_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc_out,
  output logic [31:0] if_inst_out
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d, last_pc_q, last_pc_d, tgt_q, tgt_d;
  logic [31:0] ds, nxt_pc;
  logic pend_q, pend_d, pop, rsp, push, head_keep, gnt_ok, ds_unfetched;
  logic [CW-1:0] cnt, cnt_nx;
  fetch_entry_t head;
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .data_i    ('{pc: req_pc_q, inst: imem_rdata}),
    .pop_i     (pop),
    .flush_i   (isbranch),
    .keep_i    (head_keep),
    .head_o    (head),
    .next_pc_o (nxt_pc),
    .count_o   (cnt)
  );
  assign if_valid = cnt != '0;
  assign if_pc_out = if_valid ? head.pc : '0;
  assign if_inst_out = if_valid ? head.inst : '0;
  assign imem_addr = fetch_pc_q;
  assign pop = if_valid & ~id_stall_in;
  assign rsp = imem_rvalid & (state_q == WAIT || state_q == DROP);
  assign ds = (pop ? head.pc : last_pc_q) + 32'd4;
  assign ds_unfetched = fetch_pc_q == ds;
  // head that survives this cycle's pop is the only FIFO entry a redirect may keep
  assign head_keep = pop ? (cnt > CW'(1) && nxt_pc == ds) : (if_valid && head.pc == ds);
  assign push = rsp & (state_q == WAIT) & (~isbranch | (~head_keep & req_pc_q == ds));
  assign cnt_nx = cnt - CW'(pop) + CW'(push);
  assign gnt_ok = imem_req & imem_gnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == IDLE) ? RUN :
              (state_q == RUN || rsp) ? (gnt_ok ? WAIT : RUN) :
              (isbranch && state_q == WAIT && req_pc_q != ds) ? DROP : state_q;
  end
  always_comb begin
    imem_req = ~isbranch & (state_q == RUN || rsp) & (cnt_nx < CW'(FIFO_DEPTH));
  end
  // an unrequested delay slot is fetched first; the target waits in tgt_q until it is granted
  always_comb begin
    req_pc_d = gnt_ok ? fetch_pc_q : req_pc_q;
    last_pc_d = pop ? head.pc : last_pc_q;
    tgt_d = isbranch ? branch_pc : tgt_q;
    pend_d = isbranch ? ds_unfetched : (gnt_ok ? 1'b0 : pend_q);
    fetch_pc_d = isbranch ? (ds_unfetched ? fetch_pc_q : branch_pc) :
                 gnt_ok ? (pend_q ? tgt_q : fetch_pc_q + 32'd4) : fetch_pc_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q <= '0;
      last_pc_q <= '0;
      tgt_q <= '0;
      pend_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q <= req_pc_d;
      last_pc_q <= last_pc_d;
      tgt_q <= tgt_d;
      pend_q <= pend_d;
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed checks of fetch sequencing, stalls, redirects and reset against a latency-configurable memory model
module tb_inst_fetch;
  localparam logic [31:0] RP = 32'h0040_0000;
  localparam logic [31:0] BT = 32'h0040_0100;
  logic clk = 1'b0;
  logic reset, isbranch, id_stall_in, imem_req, imem_gnt, imem_rvalid, if_valid;
  logic [31:0] branch_pc, imem_addr, imem_rdata, if_pc_out, if_inst_out, raddr;
  logic [31:0] handed[$], hinst[$], granted[$], exp_q[$];
  logic busy, stray, hold;
  int lat, cnt, phase, n_chk, n_fail;
  inst_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .isbranch    (isbranch),
    .branch_pc   (branch_pc),
    .id_stall_in (id_stall_in),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc_out   (if_pc_out),
    .if_inst_out (if_inst_out)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive();
    if (busy && cnt > 0) cnt--;
    imem_rvalid = stray || (busy && cnt == 0);
    imem_rdata = stray ? 32'hBAD0_BAD0 : (busy && cnt == 0) ? inst_of(raddr) : 32'h0;
    imem_gnt = !(hold && imem_addr == RP + 32'h14);
    #1;
  endtask
  task automatic commit();
    if (imem_req && imem_gnt) granted.push_back(imem_addr);
    if (if_valid && !id_stall_in) begin
      handed.push_back(if_pc_out);
      hinst.push_back(if_inst_out);
    end
    if (imem_rvalid && !stray) busy = 1'b0;
    if (imem_req && imem_gnt) begin
      busy = 1'b1;
      cnt = lat;
      raddr = imem_addr;
    end
    stray = 1'b0;
    @(negedge clk);
  endtask
  task automatic cyc();
    drive();
    commit();
  endtask
  task automatic check_rst(input string tag);
    check({tag, "_req"}, imem_req, 0);
    check({tag, "_addr"}, imem_addr, RP);
    check({tag, "_valid"}, if_valid, 0);
    check({tag, "_pc"}, if_pc_out, 0);
    check({tag, "_inst"}, if_inst_out, 0);
  endtask
  task automatic do_reset(input string tag, input int l);
    reset = 1'b1;
    isbranch = 1'b0;
    branch_pc = '0;
    id_stall_in = 1'b0;
    imem_rvalid = 1'b0;
    imem_gnt = 1'b0;
    imem_rdata = '0;
    busy = 1'b0;
    stray = 1'b0;
    hold = 1'b0;
    phase = 0;
    lat = l;
    handed.delete();
    hinst.delete();
    granted.delete();
    #1;
    check_rst(tag);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic exp_seq(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(RP + 32'(4 * i));
  endtask
  task automatic cmp_q(input string tag, input logic [31:0] got[$], input logic [31:0] exp[$]);
    check({tag, "_len"}, 32'(got.size() >= exp.size()), 32'd1);
    foreach (exp[i]) check($sformatf("%s_%0d", tag, i), i < got.size() ? got[i] : 32'hFFFF_FFFF, exp[i]);
  endtask
  task automatic cmp_handed(input string tag);
    logic [31:0] ei[$];
    foreach (exp_q[i]) ei.push_back(inst_of(exp_q[i]));
    cmp_q({tag, "_pc"}, handed, exp_q);
    cmp_q({tag, "_inst"}, hinst, ei);
  endtask
  task automatic absent(input string tag, input logic [31:0] a);
    int n = 0;
    foreach (handed[i]) if (handed[i] == a) n++;
    check(tag, n, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: run did not reach its end");
    $fatal(1);
  end
  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b0;
    #2;
    do_reset("t1_rst", 1);
    drive(); check("t1_c0_req", imem_req, 0); commit();
    drive(); check("t1_c1_req", imem_req, 1); check("t1_c1_addr", imem_addr, RP); commit();
    drive(); check("t1_c2_req", imem_req, 1); check("t1_c2_addr", imem_addr, RP + 4); check("t1_c2_valid", if_valid, 0); commit();
    drive(); check("t1_c3_req", imem_req, 1); check("t1_c3_addr", imem_addr, RP + 8);
    check("t1_c3_valid", if_valid, 1); check("t1_c3_pc", if_pc_out, RP); commit();
    repeat (6) cyc();
    exp_seq(7); cmp_handed("t1");
    exp_seq(9); cmp_q("t1_req", granted, exp_q);
    do_reset("t2_rst", 1);
    id_stall_in = 1'b1;
    repeat (4) cyc();
    drive(); check("t2_full_req", imem_req, 0); check("t2_full_valid", if_valid, 1);
    check("t2_full_pc", if_pc_out, RP); check("t2_full_issued", granted.size(), 2); commit();
    id_stall_in = 1'b0;
    drive(); check("t2_resume_req", imem_req, 1); check("t2_resume_addr", imem_addr, RP + 8); commit();
    repeat (5) cyc();
    exp_seq(6); cmp_handed("t2");
    exp_seq(6); cmp_q("t2_req", granted, exp_q);
    do_reset("t3_rst", 1);
    for (int c = 0; c < 16; c++) begin
      isbranch = 1'b0;
      id_stall_in = 1'b0;
      if (phase == 1) begin
        isbranch = 1'b1;
        branch_pc = BT;
        phase = 2;
      end else if (phase == 0 && if_valid && if_pc_out == RP + 16) begin
        id_stall_in = 1'b1;
        phase = 1;
      end
      cyc();
    end
    isbranch = 1'b0;
    exp_seq(6); exp_q.push_back(BT); exp_q.push_back(BT + 4); cmp_handed("t3");
    absent("t3_no_18", RP + 24);
    exp_seq(6); exp_q.push_back(BT); cmp_q("t3_req", granted, exp_q);
    do_reset("t4_rst", 3);
    for (int c = 0; c < 40; c++) begin
      isbranch = 1'b0;
      id_stall_in = 1'b0;
      if (phase == 0 && if_valid && if_pc_out == RP + 20) begin
        isbranch = 1'b1;
        id_stall_in = 1'b1;
        branch_pc = BT;
        phase = 1;
      end
      cyc();
    end
    isbranch = 1'b0;
    exp_seq(6); exp_q.push_back(BT); exp_q.push_back(BT + 4); cmp_handed("t4");
    absent("t4_no_18", RP + 24);
    exp_seq(7); exp_q.push_back(BT); exp_q.push_back(BT + 4); cmp_q("t4_req", granted, exp_q);
    do_reset("t5_rst", 1);
    hold = 1'b1;
    for (int c = 0; c < 16; c++) begin
      isbranch = 1'b0;
      if (phase == 0 && if_valid && if_pc_out == RP + 16) begin
        isbranch = 1'b1;
        branch_pc = BT;
        phase = 1;
      end
      cyc();
      if (phase == 1) hold = 1'b0;
    end
    isbranch = 1'b0;
    exp_seq(6); exp_q.push_back(BT); exp_q.push_back(BT + 4); cmp_handed("t5");
    exp_seq(6); exp_q.push_back(BT); exp_q.push_back(BT + 4); cmp_q("t5_req", granted, exp_q);
    do_reset("t6_rst", 3);
    id_stall_in = 1'b1;
    repeat (5) cyc();
    check("t6_pre_valid", if_valid, 1);
    reset = 1'b1;
    busy = 1'b0;
    #1;
    check_rst("t6_mid");
    handed.delete();
    hinst.delete();
    granted.delete();
    @(negedge clk);
    reset = 1'b0;
    id_stall_in = 1'b0;
    stray = 1'b1;
    drive(); check("t6_idle_req", imem_req, 0); commit();
    repeat (9) cyc();
    exp_seq(2); cmp_handed("t6");
    exp_seq(2); cmp_q("t6_req", granted, exp_q);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
